// File: rtl/bc_msg_arbiter.sv
// Broadcast message arbiter: per-core one-entry buffers, round-robin grant, one rebroadcast per cycle.
// Optional macro BC_SELF_FILTER_EN suppresses the originator's own broadcast valid bit.
module bc_msg_arbiter #(
  parameter int unsigned CORE_COUNT    = 16,
  parameter int unsigned CORE_ID_WIDTH = 4,
  parameter int unsigned MSG_WIDTH     = 46,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_bc_msg,
  input  logic [CORE_COUNT-1:0]           s_bc_msg_valid,
  output logic [CORE_COUNT-1:0]           s_bc_msg_ready,
  output logic [MSG_WIDTH-1:0]            m_bc_msg,
  output logic [CORE_COUNT-1:0]           m_bc_msg_valid,
  output logic [CORE_ID_WIDTH-1:0]        m_bc_msg_src,
  input  logic                            bc_hold,
  output logic [CNT_WIDTH-1:0]            bc_msg_count
);

  logic [CORE_COUNT-1:0]    buf_valid;
  logic [MSG_WIDTH-1:0]     buf_q [CORE_COUNT];
  logic [CORE_ID_WIDTH-1:0] rr_ptr;
  logic [CORE_ID_WIDTH-1:0] rr_next;
  logic [CORE_COUNT-1:0]    grant;
  logic                     gnt_any;
  logic [CORE_ID_WIDTH-1:0] gnt_idx;
  logic [CORE_COUNT-1:0]    accept;
  logic [CORE_COUNT-1:0]    bcast_mask;

  // Round-robin search upward from rr_ptr, wrapping past the last core.
  always_comb begin
    int unsigned              sum;
    logic [CORE_ID_WIDTH-1:0] idx;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = 0;
    idx     = '0;
    for (int unsigned k = 0; k < CORE_COUNT; k++) begin
      sum = 32'(rr_ptr) + k;
      if (sum >= CORE_COUNT) sum = sum - CORE_COUNT;
      idx = CORE_ID_WIDTH'(sum);
      if (!gnt_any && !bc_hold && buf_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_any    = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  assign rr_next = (gnt_idx == CORE_ID_WIDTH'(CORE_COUNT - 1)) ? '0
                                                               : gnt_idx + CORE_ID_WIDTH'(1);

  // A granted buffer can take a new message in the same cycle, so streaming has no bubble.
  assign s_bc_msg_ready = ~buf_valid | grant;
  assign accept         = s_bc_msg_valid & s_bc_msg_ready;

`ifdef BC_SELF_FILTER_EN
  assign bcast_mask = ~grant;
`else
  assign bcast_mask = '1;
`endif

  for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_buf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_q[gi] <= '0;
      end else if (accept[gi]) begin
        buf_q[gi] <= s_bc_msg[gi*MSG_WIDTH +: MSG_WIDTH];
      end
    end
  end

  // Buffer flags, arbitration pointer, broadcast output register and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid      <= '0;
      rr_ptr         <= '0;
      m_bc_msg       <= '0;
      m_bc_msg_valid <= '0;
      m_bc_msg_src   <= '0;
      bc_msg_count   <= '0;
    end else begin
      buf_valid      <= (buf_valid & ~grant) | accept;
      m_bc_msg_valid <= gnt_any ? bcast_mask : '0;
      if (gnt_any) begin
        m_bc_msg     <= buf_q[gnt_idx];
        m_bc_msg_src <= gnt_idx;
        rr_ptr       <= rr_next;
        bc_msg_count <= bc_msg_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Self-checking bench for bc_msg_arbiter against a queue-free occupancy/pointer reference model.
// Counter width is reduced so the wrap-around is reached by a plain message sequence.
module tb_bc_msg_arbiter;
  localparam int unsigned N   = 16;
  localparam int unsigned IDW = 4;
  localparam int unsigned MW  = 46;
  localparam int unsigned CW  = 8;
`ifdef BC_SELF_FILTER_EN
  localparam logic [N-1:0] SINGLE_MASK = 16'hFFF7;
`else
  localparam logic [N-1:0] SINGLE_MASK = 16'hFFFF;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*MW-1:0] s_bc_msg;
  logic [N-1:0]   s_vld, s_rdy, m_vld;
  logic [MW-1:0]  m_msg;
  logic [IDW-1:0] m_src;
  logic           hold;
  logic [CW-1:0]  cnt_o;
  logic [MW-1:0]  in_msg [N];

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit            occ [N];
  logic [MW-1:0] mb  [N];
  int            ptr, mcnt, e_src, e_grant;
  logic [MW-1:0] e_msg;
  logic [N-1:0]  e_vld, e_rdy, a_rdy, acc;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign s_bc_msg[gi*MW +: MW] = in_msg[gi];
  end

  bc_msg_arbiter #(.CORE_COUNT(N), .CORE_ID_WIDTH(IDW), .MSG_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_bc_msg(s_bc_msg), .s_bc_msg_valid(s_vld),
    .s_bc_msg_ready(s_rdy), .m_bc_msg(m_msg), .m_bc_msg_valid(m_vld),
    .m_bc_msg_src(m_src), .bc_hold(hold), .bc_msg_count(cnt_o));

  function automatic logic [N-1:0] bmask(int g);
    logic [N-1:0] m;
    m = '1;
`ifdef BC_SELF_FILTER_EN
    m[g] = 1'b0;
`endif
    return m;
  endfunction

  function automatic logic [MW-1:0] rnd_msg();
    return MW'({$urandom(), $urandom()});
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin occ[i] = 0; mb[i] = '0; end
    ptr = 0; mcnt = 0; e_src = 0; e_grant = -1; e_msg = '0; e_vld = '0; acc = '0;
  endtask

  // Called at posedge+1: samples ready, advances the model by one clock, returns at posedge+1.
  task automatic tick();
    int g;
    g = -1;
    #2;
    if (!hold)
      for (int k = 0; k < N; k++)
        if (g < 0 && occ[(ptr + k) % N]) g = (ptr + k) % N;
    for (int i = 0; i < N; i++) begin
      e_rdy[i] = !occ[i] || (g == i);
      acc[i]   = s_vld[i] && e_rdy[i];
    end
    a_rdy   = s_rdy;
    e_grant = g;
    if (g >= 0) begin
      e_msg = mb[g]; e_src = g; e_vld = bmask(g);
      mcnt  = (mcnt + 1) % (1 << CW);
      ptr   = (g + 1) % N;
    end else begin
      e_vld = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin mb[i] = in_msg[i]; occ[i] = 1; end
      else if (g == i) occ[i] = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; s_vld = '0; hold = 1'b0;
    for (int i = 0; i < N; i++) in_msg[i] = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_vld = '0; hold = 1'b0;
    for (int i = 0; i < N; i++) in_msg[i] = '0;
    model_clear();
    #1;
    checks++;
    if (m_vld !== '0 || cnt_o !== '0 || m_msg !== '0 || m_src !== '0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%h cnt=%0d msg=%h src=%0d, expected all zero", m_vld, cnt_o, m_msg, m_src);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_rdy !== '1 || m_vld !== '0 || cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_release: rdy=%h vld=%h cnt=%0d, expected rdy=ffff vld=0 cnt=0", s_rdy, m_vld, cnt_o);
    end
  endtask

  task automatic test_single();
    logic [MW-1:0] v;
    apply_reset();
    v = {32'h12345678, 4'hF, 10'h0A5};
    in_msg[3] = v; s_vld = 16'h0008;
    tick();
    s_vld = '0;
    checks++;
    if (m_vld !== '0) begin
      errors++; $display("FAIL single_lat1: vld=%h, expected 0", m_vld);
    end
    tick();
    checks++;
    if (m_msg !== v || m_src !== 4'd3 || m_vld !== SINGLE_MASK || cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL single_bcast: msg=%h src=%0d vld=%h cnt=%0d, expected msg=%h src=3 vld=%h cnt=1",
               m_msg, m_src, m_vld, cnt_o, v, SINGLE_MASK);
    end
    tick();
    checks++;
    if (m_vld !== '0 || cnt_o !== 8'd1 || m_msg !== v) begin
      errors++; $display("FAIL single_pulse_end: vld=%h cnt=%0d msg=%h, expected vld=0 cnt=1 msg=%h", m_vld, cnt_o, m_msg, v);
    end
  endtask

  task automatic test_rr_order();
    int exp_src [3];
    exp_src = '{0, 5, 15};
    apply_reset();
    in_msg[0] = rnd_msg(); in_msg[5] = rnd_msg(); in_msg[15] = rnd_msg();
    s_vld = 16'h8021;
    tick();
    s_vld = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (m_src !== IDW'(exp_src[k]) || m_vld !== bmask(exp_src[k]) || m_msg !== e_msg) begin
        errors++;
        $display("FAIL rr_order[%0d]: src=%0d vld=%h msg=%h, expected src=%0d vld=%h msg=%h",
                 k, m_src, m_vld, m_msg, exp_src[k], bmask(exp_src[k]), e_msg);
      end
    end
    tick();
    checks++;
    if (m_vld !== '0) begin errors++; $display("FAIL rr_idle: vld=%h, expected 0", m_vld); end
    // Pointer wrapped to 0: of cores 0 and 15, core 0 must win first.
    in_msg[0] = rnd_msg(); in_msg[15] = rnd_msg(); s_vld = 16'h8001;
    tick();
    s_vld = '0;
    tick();
    checks++;
    if (m_src !== 4'd0 || m_vld === '0) begin
      errors++; $display("FAIL rr_wrap_ptr: src=%0d vld=%h, expected src=0 with a pulse", m_src, m_vld);
    end
    tick();
    checks++;
    if (m_src !== 4'd15 || m_msg !== e_msg) begin
      errors++; $display("FAIL rr_wrap_next: src=%0d msg=%h, expected src=15 msg=%h", m_src, m_msg, e_msg);
    end
    tick();
  endtask

  task automatic test_stream();
    int gcnt [N];
    int c0;
    for (int i = 0; i < N; i++) begin gcnt[i] = 0; in_msg[i] = rnd_msg(); end
    c0 = mcnt;
    s_vld = '1;
    for (int k = 0; k <= 64; k++) begin
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) in_msg[i] = rnd_msg();
      if (k >= 1) begin
        if (m_vld !== '0) gcnt[m_src]++;
        checks++;
        if (m_src !== IDW'((k - 1) % N) || m_vld !== bmask((k - 1) % N) || m_msg !== e_msg
            || cnt_o !== CW'(mcnt) || a_rdy !== e_rdy) begin
          errors++;
          $display("FAIL stream[%0d]: src=%0d vld=%h msg=%h cnt=%0d rdy=%h, expected src=%0d vld=%h msg=%h cnt=%0d rdy=%h",
                   k, m_src, m_vld, m_msg, cnt_o, a_rdy, (k - 1) % N, bmask((k - 1) % N), e_msg, mcnt, e_rdy);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gcnt[i] != 4) begin errors++; $display("FAIL stream_fair core%0d: grants=%0d, expected 4", i, gcnt[i]); end
    end
    checks++;
    if (cnt_o !== CW'(c0 + 64)) begin
      errors++; $display("FAIL stream_count: cnt=%0d, expected %0d", cnt_o, (c0 + 64) % (1 << CW));
    end
    s_vld = '0;
    for (int k = 0; k < 18; k++) begin
      tick();
      checks++;
      if (m_vld !== e_vld || m_src !== IDW'(e_src) || m_msg !== e_msg || cnt_o !== CW'(mcnt)) begin
        errors++;
        $display("FAIL stream_drain[%0d]: vld=%h src=%0d msg=%h cnt=%0d, expected vld=%h src=%0d msg=%h cnt=%0d",
                 k, m_vld, m_src, m_msg, cnt_o, e_vld, e_src, e_msg, mcnt);
      end
    end
  endtask

  task automatic test_hold();
    int exp_src [4];
    exp_src = '{2, 7, 2, 7};
    hold = 1'b1;
    in_msg[2] = rnd_msg(); in_msg[7] = rnd_msg();
    s_vld = 16'h0084;
    tick();
    in_msg[2] = rnd_msg(); in_msg[7] = rnd_msg();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (a_rdy[2] !== 1'b0 || a_rdy[7] !== 1'b0 || a_rdy !== e_rdy || m_vld !== '0) begin
        errors++;
        $display("FAIL hold_full[%0d]: rdy=%h vld=%h, expected rdy=%h vld=0", k, a_rdy, m_vld, e_rdy);
      end
    end
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) s_vld[i] = 1'b0;
      checks++;
      if (m_src !== IDW'(exp_src[k]) || m_vld !== bmask(exp_src[k]) || m_msg !== e_msg) begin
        errors++;
        $display("FAIL hold_release[%0d]: src=%0d vld=%h msg=%h, expected src=%0d vld=%h msg=%h",
                 k, m_src, m_vld, m_msg, exp_src[k], bmask(exp_src[k]), e_msg);
      end
    end
    tick();
    checks++;
    if (m_vld !== '0 || s_rdy !== '1) begin
      errors++; $display("FAIL hold_idle: vld=%h rdy=%h, expected vld=0 rdy=ffff", m_vld, s_rdy);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      hold = ($urandom_range(7) == 0);
      for (int i = 0; i < N; i++)
        if (!(s_vld[i] && !acc[i])) begin
          s_vld[i]  = ($urandom_range(3) == 0);
          in_msg[i] = rnd_msg();
        end
      tick();
      checks++;
      if (m_vld !== e_vld || m_src !== IDW'(e_src) || m_msg !== e_msg || cnt_o !== CW'(mcnt) || a_rdy !== e_rdy) begin
        errors++;
        $display("FAIL random[%0d]: vld=%h src=%0d msg=%h cnt=%0d rdy=%h, expected vld=%h src=%0d msg=%h cnt=%0d rdy=%h",
                 k, m_vld, m_src, m_msg, cnt_o, a_rdy, e_vld, e_src, e_msg, mcnt, e_rdy);
      end
    end
    s_vld = '0; hold = 1'b0;
    repeat (N + 1) tick();
  endtask

  task automatic test_wrap();
    int guard;
    logic [CW-1:0] exp_cnt [3];
    exp_cnt = '{CW'((1 << CW) - 1), CW'(0), CW'(1)};
    apply_reset();
    in_msg[0] = rnd_msg(); s_vld = 16'h0001;
    guard = 0;
    while (mcnt != (1 << CW) - 2 && guard < 600) begin
      tick();
      if (acc[0]) in_msg[0] = rnd_msg();
      guard++;
    end
    checks++;
    if (guard >= 600 || cnt_o !== CW'((1 << CW) - 2)) begin
      errors++; $display("FAIL wrap_approach: cnt=%0d after %0d cycles, expected %0d", cnt_o, guard, (1 << CW) - 2);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (acc[0]) in_msg[0] = rnd_msg();
      checks++;
      if (cnt_o !== exp_cnt[k] || m_src !== 4'd0 || m_vld !== bmask(0) || m_msg !== e_msg) begin
        errors++;
        $display("FAIL wrap[%0d]: cnt=%0d src=%0d vld=%h, expected cnt=%0d src=0 vld=%h",
                 k, cnt_o, m_src, m_vld, exp_cnt[k], bmask(0));
      end
    end
    s_vld = '0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) in_msg[i] = rnd_msg();
    s_vld = 16'h0212;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) in_msg[i] = rnd_msg();
    end
    checks++;
    if (m_vld === '0) begin errors++; $display("FAIL reset_mid_pre: vld=%h, expected a pulse in flight", m_vld); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_vld !== '0 || cnt_o !== '0 || m_msg !== '0 || m_src !== '0 || s_rdy !== '1) begin
      errors++;
      $display("FAIL reset_mid_async: vld=%h cnt=%0d msg=%h src=%0d rdy=%h, expected zeros and rdy=ffff",
               m_vld, cnt_o, m_msg, m_src, s_rdy);
    end
    model_clear();
    s_vld = '0; hold = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (m_vld !== '0 || a_rdy !== '1 || cnt_o !== '0) begin
        errors++;
        $display("FAIL reset_mid_stale[%0d]: vld=%h rdy=%h cnt=%0d, expected vld=0 rdy=ffff cnt=0", k, m_vld, a_rdy, cnt_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_stream();
    test_hold();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bc_msg_arbiter.md
Name: bc_msg_arbiter

Overview:
- Collects broadcast messages from the bc_msg_out handshake port of every RISC-V block and rebroadcasts one message per cycle to all blocks' bc_msg_in/bc_msg_in_valid inputs.
- Sits directly downstream (and upstream) of the per-core wrapper.
- Provides per-core one-entry buffering, round-robin arbitration, a global hold, and a wrap-around message counter.

Parameters:
- CORE_COUNT, 16, number of attached RISC-V blocks.
- CORE_ID_WIDTH, 4, width of source core index; must be at least clog2(CORE_COUNT).
- MSG_WIDTH, 46, broadcast message width: {32b data, 4b strobe, 10b word address}; passed through unmodified.
- CNT_WIDTH, 32, width of the broadcast message counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- s_bc_msg  input  CORE_COUNT*MSG_WIDTH  per-core message; core i occupies bits [i*MSG_WIDTH +: MSG_WIDTH].
- s_bc_msg_valid  input  CORE_COUNT  per-core message valid.
- s_bc_msg_ready  output  CORE_COUNT  per-core ready.
- m_bc_msg  output  MSG_WIDTH  broadcast message, shared by all cores.
- m_bc_msg_valid  output  CORE_COUNT  per-core broadcast valid, one-cycle pulse; no backpressure.
- m_bc_msg_src  output  CORE_ID_WIDTH  index of the originating core.
- bc_hold  input  1  when high, no grant is issued.
- bc_msg_count  output  CNT_WIDTH  number of messages broadcast since reset.

Behaviour:
- Reset (asynchronous, rst_n low): buf_valid=0, rr_ptr=0, m_bc_msg=0, m_bc_msg_valid=0, m_bc_msg_src=0, bc_msg_count=0.
  - s_bc_msg_ready is 1 for every core as soon as rst_n is released.
  - A reset asserted mid-operation discards all buffered messages; no partial broadcast occurs.
- Input buffer, per core i:
  - One register, buf[i], with flag buf_valid[i].
  - s_bc_msg_ready[i] = !buf_valid[i] || grant[i].
  - On s_bc_msg_valid[i] && s_bc_msg_ready[i], buf[i] is loaded at the clock edge.
  - A grant and a new accept in the same cycle keep buf_valid[i]=1 and hold the new message, so there is no bubble.
- Arbitration:
  - Combinational round-robin over buf_valid, searching upward from rr_ptr with wrap from CORE_COUNT-1 to 0.
  - At most one grant per cycle; no grant while bc_hold=1.
  - On a grant to core g, rr_ptr <= (g+1) mod CORE_COUNT.
  - With no grant, rr_ptr holds.
- Output register, on a grant to core g:
  - m_bc_msg <= buf[g].
  - m_bc_msg_src <= g.
  - m_bc_msg_valid <= all ones.
  - buf_valid[g] clears unless a new message is accepted in the same cycle.
- Without a grant: m_bc_msg_valid <= 0. m_bc_msg and m_bc_msg_src hold their last value.
- Latency: handshake at edge T gives m_bc_msg_valid high for the cycle following edge T+1, i.e. 2 cycles when uncontested and not held.
- Throughput: one broadcast per cycle when any buffer is full.
- Fairness:
  - Under full load, each core is granted exactly once per CORE_COUNT cycles.
  - With a single core streaming continuously, that core is granted every cycle.
- Counter:
  - bc_msg_count increments by 1 per grant.
  - It wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- bc_hold:
  - Buffers fill while held, then s_bc_msg_ready drops to 0 for full cores.
  - A message already in the output register still completes its one-cycle pulse.
  - Deasserting bc_hold resumes arbitration from the unchanged rr_ptr.
- Message order from a single core is preserved. Order across cores is defined only by the arbitration.

Optional Feature:
- Macro BC_SELF_FILTER_EN.
- Defined: on a grant to g, m_bc_msg_valid <= ~(1<<g), so the originator does not receive its own message. The counter is unaffected.
- Not defined: all CORE_COUNT bits of m_bc_msg_valid pulse together, and the originator sees its own message (loopback).

Test Plan:
- Reset, then core 3 sends 0x12345678_F_0A5 (a single valid beat): 2 cycles later m_bc_msg=that value, m_bc_msg_src=3, m_bc_msg_valid=16'hFFFF for one cycle (16'hFFF7 with BC_SELF_FILTER_EN), bc_msg_count=1.
- Cores 0, 5 and 15 each present one message in the same cycle with rr_ptr=0: broadcasts emerge in src order 0, 5, 15 on consecutive cycles; final rr_ptr=0 (wrap).
- All 16 cores stream continuously for 64 cycles: every core is granted exactly 4 times, in src sequence 0..15 repeating; bc_msg_count=64; no gaps in m_bc_msg_valid.
- bc_hold=1 while cores 2 and 7 each send 2 messages: each accepts 1 message, then s_bc_msg_ready[2] and s_bc_msg_ready[7] are 0. Release hold: 4 broadcasts in order 2, 7, 2, 7.
- Force bc_msg_count near wrap (2^32-2) via sequence or backdoor, then send 3 messages: count reads 2^32-1, 0, 1.
- Assert rst_n low while 3 buffers are full and a broadcast pulse is in progress: all valids drop immediately (asynchronously). After release, no stale message is broadcast and all readies are 1.
